// File: rtl/mem_ctrl.sv
// Load/store front end for the word-addressed data RAM.
// Byte/half stores use read-modify-write; loads extract and extend the addressed lane.
module mem_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [29:0] o_ram_addr,
  output logic [31:0] o_ram_din,
  output logic        o_ram_re,
  output logic        o_ram_we,
  input  logic [31:0] i_ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MERGE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [29:0] r_waddr;
  logic [1:0]  r_boff;
  logic [15:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_req_err;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  logic [31:0] w_merged;

  assign w_req_err = (i_req_size == 2'd3) ||
                     (i_req_size == 2'd1 && i_req_addr[0]) ||
                     (i_req_size == 2'd2 && i_req_addr[1:0] != 2'd0);

  // Shifting the addressed lane down to bit 0 serves both byte and half loads.
  assign w_lane = i_ram_dout >> {r_boff, 3'b000};

  always_comb begin
    w_load_data = i_ram_dout;
    case (r_size)
      2'd0:    w_load_data = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
      2'd1:    w_load_data = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
      default: w_load_data = i_ram_dout;
    endcase
  end

  always_comb begin
    w_mask = 32'h0;
    w_ins  = 32'h0;
    if (r_size == 2'd0) begin
      w_mask = 32'h0000_00FF << {r_boff, 3'b000};
      w_ins  = {24'h0, r_wdata[7:0]} << {r_boff, 3'b000};
    end else if (r_size == 2'd1) begin
      w_mask = 32'h0000_FFFF << {r_boff[1], 4'b0000};
      w_ins  = {16'h0, r_wdata} << {r_boff[1], 4'b0000};
    end
  end

  assign w_merged = (i_ram_dout & ~w_mask) | (w_ins & w_mask);

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_ram_re    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = r_waddr;
    o_ram_din   = w_merged;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        o_ram_addr  = i_req_addr[31:2];
        o_ram_din   = i_req_wdata;
        if (i_req_valid) begin
          if (w_req_err) begin
            w_next = S_RESP;
          end else if (!i_req_we) begin
            o_ram_re = 1'b1;
            w_next   = S_LOAD;
          end else if (i_req_size == 2'd2) begin
            o_ram_we = 1'b1;
            w_next   = S_RESP;
          end else begin
            o_ram_re = 1'b1;
            w_next   = S_MERGE;
          end
        end
      end
      S_LOAD:  w_next = S_RESP;
      S_MERGE: begin
        o_ram_we = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Gated combinationally so a reset during MERGE drops the write at once.
    if (i_reset) begin
      o_req_ready = 1'b0;
      o_ram_re    = 1'b0;
      o_ram_we    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_boff  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_req_valid) begin
        r_waddr <= i_req_addr[31:2];
        r_boff  <= i_req_addr[1:0];
        r_wdata <= i_req_wdata[15:0];
        r_size  <= i_req_size;
        r_uns   <= i_req_unsigned;
        r_rdata <= '0;
        r_err   <= w_req_err;
      end
      if (r_state == S_LOAD) begin
        r_rdata <= w_load_data;
      end
    end
  end

  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 1-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [29:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_dout;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  int we_cnt = 0;
  int both_hi = 0;
  int oob = 0;

  logic        c_we [4];
  logic        c_re [4];
  logic        c_rv [4];
  logic        c_rdy [4];
  logic [31:0] c_din;
  logic [31:0] c_rdata;
  logic        c_err;

  mem_ctrl dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_ram_addr(ram_addr), .o_ram_din(ram_din),
    .o_ram_re(ram_re), .o_ram_we(ram_we), .i_ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we && ram_re) both_hi++;
    if ((ram_we || ram_re) && ram_addr[29:8] != 22'd0) oob++;
    if (ram_we) begin
      we_cnt++;
      mem[ram_addr[7:0]] <= ram_din;
    end
    if (ram_re) ram_dout <= mem[ram_addr[7:0]];
  end

  // Issues one request and captures DUT activity for cycles T..T+3.
  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic uns);
    @(negedge clk);
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    req_unsigned = uns; req_valid = 1'b1;
    c_din = 'x; c_rdata = 'x; c_err = 1'bx;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) #1; else @(negedge clk);
      c_we[k] = ram_we; c_re[k] = ram_re; c_rv[k] = resp_valid; c_rdy[k] = req_ready;
      if (ram_we) c_din = ram_din;
      if (resp_valid) begin c_rdata = resp_rdata; c_err = resp_err; end
      if (k == 0) begin @(posedge clk); #1 req_valid = 1'b0; end
    end
  endtask

  task automatic test_reset();
    logic seen;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h100;
    @(negedge clk); @(negedge clk);
    checks++; if ({req_ready, ram_re, ram_we} !== 3'b000) begin failures++;
      $display("FAIL reset_handshake got=%b exp=000", {req_ready, ram_re, ram_we}); end
    checks++; if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin failures++;
      $display("FAIL reset_resp got=%b/%b/%h exp=0/0/0", resp_valid, resp_err, resp_rdata); end
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin failures++;
      $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (resp_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++;
      $display("FAIL idle_no_resp got=%b exp=0", seen); end
  endtask

  task automatic test_word();
    do_req(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b0);
    checks++; if ({c_we[0], c_rv[1], c_rv[2]} !== 3'b110) begin failures++;
      $display("FAIL sw_timing got=%b exp=110", {c_we[0], c_rv[1], c_rv[2]}); end
    checks++; if (c_din !== 32'hDEADBEEF) begin failures++;
      $display("FAIL sw_din got=%h exp=deadbeef", c_din); end
    checks++; if ({c_err, c_rdata} !== 33'd0) begin failures++;
      $display("FAIL sw_resp got=%b/%h exp=0/0", c_err, c_rdata); end
    do_req(1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
    checks++; if ({c_re[0], c_rv[1], c_rv[2], c_rdy[1]} !== 4'b1010) begin failures++;
      $display("FAIL lw_timing got=%b exp=1010", {c_re[0], c_rv[1], c_rv[2], c_rdy[1]}); end
    checks++; if (c_rdata !== 32'hDEADBEEF) begin failures++;
      $display("FAIL lw_data got=%h exp=deadbeef", c_rdata); end
  endtask

  task automatic test_byte();
    int w0;
    do_req(1'b1, 2'd2, 32'h100, 32'h11223344, 1'b0);
    w0 = we_cnt;
    do_req(1'b1, 2'd0, 32'h101, 32'h000000AA, 1'b0);
    checks++; if ({c_re[0], c_we[0], c_we[1], c_rv[2]} !== 4'b1011) begin failures++;
      $display("FAIL sb_timing got=%b exp=1011", {c_re[0], c_we[0], c_we[1], c_rv[2]}); end
    checks++; if (we_cnt - w0 !== 1) begin failures++;
      $display("FAIL sb_we_count got=%0d exp=1", we_cnt - w0); end
    checks++; if (c_din !== 32'h1122AA44) begin failures++;
      $display("FAIL sb_din got=%h exp=1122aa44", c_din); end
    do_req(1'b0, 2'd0, 32'h101, 32'h0, 1'b0);
    checks++; if (c_rdata !== 32'hFFFFFFAA) begin failures++;
      $display("FAIL lb_data got=%h exp=ffffffaa", c_rdata); end
    do_req(1'b0, 2'd0, 32'h101, 32'h0, 1'b1);
    checks++; if (c_rdata !== 32'h000000AA) begin failures++;
      $display("FAIL lbu_data got=%h exp=000000aa", c_rdata); end
    do_req(1'b0, 2'd0, 32'h103, 32'h0, 1'b1);
    checks++; if (c_rdata !== 32'h00000011) begin failures++;
      $display("FAIL lbu3_data got=%h exp=00000011", c_rdata); end
  endtask

  task automatic test_half();
    do_req(1'b1, 2'd1, 32'h102, 32'h00008001, 1'b0);
    checks++; if (mem[8'h40] !== 32'h8001AA44) begin failures++;
      $display("FAIL sh_word got=%h exp=8001aa44", mem[8'h40]); end
    do_req(1'b0, 2'd1, 32'h102, 32'h0, 1'b0);
    checks++; if (c_rdata !== 32'hFFFF8001) begin failures++;
      $display("FAIL lh_data got=%h exp=ffff8001", c_rdata); end
    do_req(1'b0, 2'd1, 32'h102, 32'h0, 1'b1);
    checks++; if (c_rdata !== 32'h00008001) begin failures++;
      $display("FAIL lhu_data got=%h exp=00008001", c_rdata); end
    do_req(1'b0, 2'd1, 32'h100, 32'h0, 1'b0);
    checks++; if (c_rdata !== 32'hFFFFAA44) begin failures++;
      $display("FAIL lh0_data got=%h exp=ffffaa44", c_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  re_b, rv_b;
    logic [31:0] d_b;
    d_b = 'x;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h100; req_unsigned = 1'b0; req_valid = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      re_b[k] = ram_re; rv_b[k] = resp_valid;
      if (resp_valid) d_b = resp_rdata;
    end
    req_valid = 1'b0;
    checks++; if (re_b !== 6'b001001) begin failures++;
      $display("FAIL b2b_re got=%b exp=001001", re_b); end
    checks++; if (rv_b !== 6'b100100) begin failures++;
      $display("FAIL b2b_rv got=%b exp=100100", rv_b); end
    checks++; if (d_b !== 32'h8001AA44) begin failures++;
      $display("FAIL b2b_data got=%h exp=8001aa44", d_b); end
  endtask

  task automatic test_errors();
    logic [34:0] vec [4];
    logic        act;
    vec[0] = {1'b0, 2'd1, 32'h103};
    vec[1] = {1'b0, 2'd2, 32'h102};
    vec[2] = {1'b1, 2'd2, 32'h101};
    vec[3] = {1'b0, 2'd3, 32'h100};
    for (int i = 0; i < 4; i++) begin
      do_req(vec[i][34], vec[i][33:32], vec[i][31:0], 32'hFFFFFFFF, 1'b0);
      act = c_we[0] | c_we[1] | c_we[2] | c_we[3] | c_re[0] | c_re[1] | c_re[2] | c_re[3];
      checks++; if ({c_rv[1], c_err, c_rdata} !== {2'b11, 32'h0}) begin failures++;
        $display("FAIL err_resp[%0d] got=%b/%b/%h exp=1/1/0", i, c_rv[1], c_err, c_rdata); end
      checks++; if (act !== 1'b0) begin failures++;
        $display("FAIL err_ram_access[%0d] got=%b exp=0", i, act); end
    end
    checks++; if (mem[8'h40] !== 32'h8001AA44) begin failures++;
      $display("FAIL err_mem got=%h exp=8001aa44", mem[8'h40]); end
  endtask

  task automatic test_reset_merge();
    int   w0;
    logic mwe, seen;
    w0 = we_cnt;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h100; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; reset = 1'b1; #1;
    mwe = ram_we;
    checks++; if (mwe !== 1'b0) begin failures++;
      $display("FAIL merge_reset_we got=%b exp=0", mwe); end
    seen = 1'b0;
    @(negedge clk); if (resp_valid) seen = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin failures++;
      $display("FAIL merge_reset_ready got=%b exp=1", req_ready); end
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++;
      $display("FAIL merge_reset_resp got=%b exp=0", seen); end
    checks++; if (we_cnt - w0 !== 0) begin failures++;
      $display("FAIL merge_reset_we_count got=%0d exp=0", we_cnt - w0); end
    checks++; if (mem[8'h40] !== 32'h8001AA44) begin failures++;
      $display("FAIL merge_reset_mem got=%h exp=8001aa44", mem[8'h40]); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_back_to_back();
    test_errors();
    test_reset_merge();
    checks++; if (both_hi !== 0) begin failures++;
      $display("FAIL re_we_both got=%0d exp=0", both_hi); end
    checks++; if (oob !== 0) begin failures++;
      $display("FAIL ram_addr_range got=%0d exp=0", oob); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Load/store front end for the word-addressed data RAM. Accepts one byte-addressed CPU memory request at a time and handles byte, halfword and word sizes. Sub-word stores use read-modify-write, because the RAM has no byte enables. Sits directly upstream of the RAM and drives its addr/din/re/we, consuming its 1-cycle-latency dout.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; request accepted when req_valid && req_ready.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error).
- req_unsigned  in  1  loads: zero-extend if 1, sign-extend if 0; ignored for word and stores.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request; valid only with resp_valid.
- ram_addr  out  30  RAM word address.
- ram_din  out  32  RAM write data.
- ram_re  out  1  RAM read enable.
- ram_we  out  1  RAM write enable.
- ram_dout  in  32  RAM read data, valid the cycle after ram_re.

## Operation
- States: IDLE, LOAD, MERGE, RESP. Only one request is outstanding at a time.
- IDLE: req_ready = 1. On accept, latch addr[31:2], addr[1:0], wdata, size, unsigned, we.
  - Error on size 3, on half with addr[0] = 1, or on word with addr[1:0] != 0. Go to RESP with err = 1 and rdata = 0. No RAM access.
  - Load: same cycle, ram_re = 1 and ram_addr = req_addr[31:2]. Go to LOAD.
  - Word store: same cycle, ram_we = 1, ram_addr = req_addr[31:2], ram_din = req_wdata. Go to RESP.
  - Byte/half store: same cycle, ram_re = 1. Go to MERGE.
- LOAD: extract the lane from ram_dout, extend it, and register the result into resp_rdata. Go to RESP.
  - Little-endian lanes: byte k = bits [8k+7:8k], k = addr[1:0]; half = [15:0] if addr[1] = 0, else [31:16].
- MERGE: drive ram_we = 1, ram_addr = latched word address, ram_din = ram_dout with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- RESP: resp_valid = 1 for exactly this cycle; req_ready = 0. Go to IDLE.
- ram_re and ram_we are 0 in every case not listed above; they are never both 1. ram_din is don't-care when ram_we = 0.
- ram_addr always carries the full word address; range wrap is the RAM's concern.

## Timing
- Accept at cycle T.
  - Word store: ram_we at T; resp_valid at T+1.
  - Load: ram_re at T; resp_valid with data at T+2.
  - Sub-word store: ram_re at T; ram_we at T+1; resp_valid at T+2.
  - Error: resp_valid with resp_err at T+1.
- Maximum throughput is one request per 2 cycles (word store or error) or per 3 cycles (others). req_ready is 0 in LOAD, MERGE and RESP.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0. While reset is high, req_ready, ram_re and ram_we are forced to 0.
- Reset mid-operation aborts immediately.
  - Reset during MERGE: the write is dropped and the RAM word is unchanged.
  - A word store is already committed at T.
- req_valid held high continuously: the next request is accepted in the first IDLE cycle after RESP.

## Test plan
- Reset: with reset high, all outputs are 0. After release, req_ready = 1 and resp_valid stays 0 with no requests.
- Word round-trip: sw 0xDEADBEEF at 0x100 gives ram_we at T and resp_valid at T+1. lw 0x100 then gives resp_rdata 0xDEADBEEF at T+2.
- Byte RMW: word 0x40 = 0x11223344. sb 0xAA at 0x101 gives exactly one ram_we, at T+1, with din 0x1122AA44. lb 0x101 returns 0xFFFFFFAA; lbu 0x101 returns 0x000000AA.
- Halfword: sh 0x8001 at 0x102 over 0x1122AA44 leaves the word at 0x8001AA44. lh 0x102 returns 0xFFFF8001; lhu 0x102 returns 0x00008001.
- Errors: lh 0x103, lw 0x102, sw 0x101 and size 3 each give resp_err = 1 and rdata 0 at T+1. No ram_re/ram_we, and memory is unchanged.
- Reset during MERGE of sb 0x55 at 0x100: no ram_we, word unchanged, no resp_valid, and req_ready = 1 after release.
